// File: rtl/usb_rx_decoder.sv
// USB host receive path: SYNC detect, NRZI decode, bit unstuffing, LSB-first byte assembly, EOP detect.
// Optional first-byte PID check is compiled in when USB_RX_PID_CHECK_EN is defined.
module usb_rx_decoder #(
    parameter int MAX_BYTES   = 16,
    parameter int STUFF_LIMIT = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       DP_in,
    input  logic       DM_in,
    input  logic       enable,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       pkt_start,
    output logic       pkt_end,
    output logic       pkt_error
);

    localparam int BCW = $clog2(MAX_BYTES + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP,
        ST_WAIT
    } state_t;

    state_t         state_q, state_d;
    logic           prev_k_q, prev_k_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]     ones_cnt_q, ones_cnt_d;
    logic [1:0]     se0_cnt_q, se0_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic           seen_se0_q, seen_se0_d;
    logic [6:0]     shift_q, shift_d;
    logic [7:0]     byte_out_q, byte_out_d;
    logic           byte_valid_q, byte_valid_d;
    logic           pkt_start_q, pkt_start_d;
    logic           pkt_end_q, pkt_end_d;
    logic           pkt_error_q, pkt_error_d;

    logic       line_j, line_k, line_se0, line_se1;
    logic       dbit;
    logic       err;
    logic [7:0] new_byte;

    assign line_j   =  DP_in & ~DM_in;
    assign line_k   = ~DP_in &  DM_in;
    assign line_se0 = ~DP_in & ~DM_in;
    assign line_se1 =  DP_in &  DM_in;

    // NRZI: an unchanged J/K level decodes as 1.
    assign dbit     = ~(line_k ^ prev_k_q);
    assign new_byte = {dbit, shift_q};

    always_comb begin
        state_d      = state_q;
        prev_k_d     = prev_k_q;
        bit_cnt_d    = bit_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        se0_cnt_d    = se0_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        seen_se0_d   = seen_se0_q;
        shift_d      = shift_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        pkt_start_d  = 1'b0;
        pkt_end_d    = 1'b0;
        pkt_error_d  = 1'b0;
        err          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                prev_k_d = 1'b0;
                if (line_k) begin
                    state_d    = ST_SYNC;
                    prev_k_d   = 1'b1;
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                    se0_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end

            // bit_cnt doubles as the SYNC position counter: six 0s then a 1.
            ST_SYNC: begin
                if (line_j || line_k) begin
                    prev_k_d = line_k;
                    if (bit_cnt_q == 3'd6) begin
                        if (dbit) begin
                            state_d     = ST_DATA;
                            pkt_start_d = 1'b1;
                            ones_cnt_d  = 3'd1;
                            bit_cnt_d   = '0;
                        end else begin
                            err = 1'b1;
                        end
                    end else if (dbit) begin
                        err = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    err = 1'b1;
                end
            end

            ST_DATA: begin
                if (line_se1) begin
                    err = 1'b1;
                end else if (line_se0) begin
                    if (bit_cnt_q != 3'd0 || byte_cnt_q == '0) begin
                        err = 1'b1;
                    end else begin
                        state_d   = ST_EOP;
                        se0_cnt_d = 2'd1;
                    end
                end else begin
                    prev_k_d = line_k;
                    if (ones_cnt_q == 3'(STUFF_LIMIT)) begin
                        if (dbit) begin
                            err = 1'b1;
                        end else begin
                            ones_cnt_d = '0;
                        end
                    end else begin
                        shift_d    = new_byte[7:1];
                        ones_cnt_d = dbit ? ones_cnt_q + 3'd1 : 3'd0;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            if (byte_cnt_q == BCW'(MAX_BYTES)) begin
                                err = 1'b1;
                            end
`ifdef USB_RX_PID_CHECK_EN
                            else if (byte_cnt_q == '0 && new_byte[7:4] != ~new_byte[3:0]) begin
                                err = 1'b1;
                            end
`endif
                            else begin
                                byte_cnt_d   = byte_cnt_q + 1'b1;
                                byte_out_d   = new_byte;
                                byte_valid_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end

            // se0_cnt holds the SE0 samples seen so far, including the one that entered EOP.
            ST_EOP: begin
                if (line_se0) begin
                    if (se0_cnt_q == 2'd3) begin
                        err = 1'b1;
                    end else begin
                        se0_cnt_d = se0_cnt_q + 2'd1;
                    end
                end else if (line_j && se0_cnt_q >= 2'd2) begin
                    state_d   = ST_IDLE;
                    prev_k_d  = 1'b0;
                    pkt_end_d = 1'b1;
                end else begin
                    err = 1'b1;
                end
            end

            ST_WAIT: begin
                if (line_se0) begin
                    seen_se0_d = 1'b1;
                end else if (line_j && seen_se0_q) begin
                    state_d    = ST_IDLE;
                    prev_k_d   = 1'b0;
                    seen_se0_d = 1'b0;
                end else if (!line_j) begin
                    seen_se0_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An SE0 that triggers the error counts toward the SE0,J recovery sequence.
        if (err) begin
            state_d      = ST_WAIT;
            seen_se0_d   = line_se0;
            pkt_error_d  = 1'b1;
            byte_valid_d = 1'b0;
            byte_out_d   = byte_out_q;
        end

        if (!enable) begin
            state_d      = ST_IDLE;
            prev_k_d     = 1'b0;
            bit_cnt_d    = '0;
            ones_cnt_d   = '0;
            se0_cnt_d    = '0;
            byte_cnt_d   = '0;
            seen_se0_d   = 1'b0;
            byte_valid_d = 1'b0;
            pkt_start_d  = 1'b0;
            pkt_end_d    = 1'b0;
            pkt_error_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            prev_k_q     <= 1'b0;
            bit_cnt_q    <= '0;
            ones_cnt_q   <= '0;
            se0_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            seen_se0_q   <= 1'b0;
            shift_q      <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            pkt_start_q  <= 1'b0;
            pkt_end_q    <= 1'b0;
            pkt_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_k_q     <= prev_k_d;
            bit_cnt_q    <= bit_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            se0_cnt_q    <= se0_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            seen_se0_q   <= seen_se0_d;
            shift_q      <= shift_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            pkt_start_q  <= pkt_start_d;
            pkt_end_q    <= pkt_end_d;
            pkt_error_q  <= pkt_error_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign pkt_start  = pkt_start_q;
    assign pkt_end    = pkt_end_q;
    assign pkt_error  = pkt_error_q;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: bench-side NRZI/stuffing encoder drives packets,
// a negedge monitor tallies strobes and received bytes.
module tb_usb_rx_decoder;

    localparam logic [1:0] L_J   = 2'b10;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_SE0 = 2'b00;
    localparam logic [1:0] L_SE1 = 2'b11;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       DP_in;
    logic       DM_in;
    logic       enable;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       pkt_start;
    logic       pkt_end;
    logic       pkt_error;

    usb_rx_decoder #(
        .MAX_BYTES   (16),
        .STUFF_LIMIT (6)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .DP_in      (DP_in),
        .DM_in      (DM_in),
        .enable     (enable),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .pkt_start  (pkt_start),
        .pkt_end    (pkt_end),
        .pkt_error  (pkt_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int         n_start = 0;
    int         n_end   = 0;
    int         n_err   = 0;
    logic [7:0] got[$];

    always @(negedge clock) begin
        if (reset_n) begin
            if (pkt_start)  n_start++;
            if (pkt_end)    n_end++;
            if (pkt_error)  n_err++;
            if (byte_valid) got.push_back(byte_out);
        end
    end

    int         s_start, s_end, s_err, s_bytes;
    logic       cur_k;
    int         ones;
    logic [7:0] tx[$];

    task automatic chk(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic snap();
        s_start = n_start;
        s_end   = n_end;
        s_err   = n_err;
        s_bytes = got.size();
    endtask

    task automatic check_pkt(input string tag, input int e_start, input int e_end,
                             input int e_err, input int e_bytes);
        chk({tag, "_start"}, n_start - s_start, e_start);
        chk({tag, "_end"},   n_end - s_end,     e_end);
        chk({tag, "_err"},   n_err - s_err,     e_err);
        chk({tag, "_bytes"}, got.size() - s_bytes, e_bytes);
    endtask

    task automatic send_sym(input logic [1:0] v);
        @(negedge clock);
        {DP_in, DM_in} = v;
    endtask

    task automatic idle(input int n);
        cur_k = 1'b0;
        repeat (n) send_sym(L_J);
    endtask

    task automatic send_sync();
        send_sym(L_K); send_sym(L_J); send_sym(L_K); send_sym(L_J);
        send_sym(L_K); send_sym(L_J); send_sym(L_K); send_sym(L_K);
        cur_k = 1'b1;
        ones  = 1;
    endtask

    task automatic send_raw(input logic b);
        if (!b) cur_k = ~cur_k;
        send_sym(cur_k ? L_K : L_J);
        ones = b ? ones + 1 : 0;
    endtask

    // Encoder side: insert a toggle after six consecutive 1s.
    task automatic send_bit(input logic b);
        send_raw(b);
        if (ones == 6) send_raw(1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_eop(input int n_se0);
        repeat (n_se0) send_sym(L_SE0);
        send_sym(L_J);
        cur_k = 1'b0;
    endtask

    task automatic send_packet(input int n_se0);
        send_sync();
        foreach (tx[i]) send_byte(tx[i]);
        send_eop(n_se0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        {DP_in, DM_in} = L_J;
        cur_k = 1'b0;
        ones  = 0;
        repeat (3) @(negedge clock);
        chk("rst_byte_out",   byte_out,   8'h00);
        chk("rst_byte_valid", byte_valid, 1'b0);
        chk("rst_pkt_start",  pkt_start,  1'b0);
        chk("rst_pkt_end",    pkt_end,    1'b0);
        chk("rst_pkt_error",  pkt_error,  1'b0);
        reset_n = 1'b1;
        idle(4);

        // ACK packet, with pkt_start latency checked one cycle after the last SYNC sample
        tx = '{8'hD2};
        snap();
        send_sync();
        @(posedge clock); #1;
        chk("ack_start_lat", pkt_start, 1'b1);
        send_byte(8'hD2);
        send_eop(2);
        idle(3);
        check_pkt("ack", 1, 1, 0, 1);
        chk("ack_byte", got[s_bytes], 8'hD2);

        // Stuffed bits removed
        tx = '{8'hC3, 8'hFF, 8'hFF};
        snap();
        send_packet(2);
        idle(3);
        check_pkt("stuff", 1, 1, 0, 3);
        chk("stuff_b0", got[s_bytes],     8'hC3);
        chk("stuff_b1", got[s_bytes + 1], 8'hFF);
        chk("stuff_b2", got[s_bytes + 2], 8'hFF);

        // Missing stuff bit after PID
        snap();
        send_sync();
        send_byte(8'hD2);
        repeat (7) send_raw(1'b1);
        send_eop(2);
        idle(3);
        check_pkt("stufferr", 1, 0, 1, 1);

        // Partial byte before EOP
        snap();
        send_sync();
        send_byte(8'hC3);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_eop(2);
        idle(3);
        check_pkt("partial", 1, 0, 1, 1);
        chk("partial_b0", got[s_bytes], 8'hC3);

        // 17 bytes: the 17th is replaced by an error
        tx = '{8'hD2};
        for (int i = 0; i < 16; i++) tx.push_back(8'(i * 17));
        snap();
        send_packet(2);
        idle(3);
        check_pkt("overlen", 1, 0, 1, 16);
        chk("overlen_b1",  got[s_bytes + 1],  8'h00);
        chk("overlen_b15", got[s_bytes + 15], 8'hEE);

        // Abort mid-byte with enable low for one cycle while the line shows SE1
        idle(2);
        send_sync();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        snap();
        @(negedge clock);
        enable = 1'b0;
        {DP_in, DM_in} = L_SE1;
        @(negedge clock);
        enable = 1'b1;
        {DP_in, DM_in} = L_J;
        idle(3);
        check_pkt("abort", 0, 0, 0, 0);
        tx = '{8'hD2};
        snap();
        send_packet(2);
        idle(3);
        check_pkt("abort_ack", 1, 1, 0, 1);
        chk("abort_ack_byte", got[s_bytes], 8'hD2);

        // SE1 in IDLE ignored; EOP with three SE0 samples is clean
        send_sym(L_SE1);
        idle(2);
        snap();
        send_packet(3);
        idle(3);
        check_pkt("eop3", 1, 1, 0, 1);

        // Four SE0 samples is an error
        snap();
        send_packet(4);
        idle(3);
        check_pkt("eop4", 1, 0, 1, 1);

        // Single SE0 then J is an error; a later SE0,J recovers
        snap();
        send_packet(1);
        send_eop(1);
        idle(3);
        check_pkt("eop1", 1, 0, 1, 1);

        // First byte failing the PID complement test
        tx = '{8'hD3};
        snap();
        send_packet(2);
        idle(3);
`ifdef USB_RX_PID_CHECK_EN
        check_pkt("pid", 1, 0, 1, 0);
`else
        check_pkt("pid", 1, 1, 0, 1);
        chk("pid_byte", got[s_bytes], 8'hD3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
